// File: rtl/ctrl_decode_pipe.sv
// rtl/ctrl_decode_pipe.sv - registered MIPS main decoder with ID/EX register, M-stage delay chain and load-use interlock
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (adds IllegalE output)
module ctrl_decode_pipe #(
   parameter int ALU_OP_W = 4,
   parameter int M_DELAY  = 1,
   parameter int LU_INTLK = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [31:0]         InstrD,
   input  logic                ValidD,
   output logic                ReadyD,
   input  logic                StallE,
   input  logic                FlushE,
   output logic                LoadUseStall,
   output logic                ValidE,
   output logic                SignOrZeroE,
   output logic                RegDstE,
   output logic [1:0]          ALUSrcE,
   output logic [ALU_OP_W-1:0] ALUCtrlE,
   output logic                BranchE,
   output logic [2:0]          BrCondE,
   output logic [4:0]          RsE,
   output logic [4:0]          RtE,
   output logic [4:0]          RdE,
`ifdef DECODE_ILLEGAL_TRAP_EN
   output logic                IllegalE,
`endif
   output logic                ValidM,
   output logic                RegWriteM,
   output logic                MemWriteM,
   output logic                MemToRegM,
   output logic                JumpM,
   output logic                JALValM,
   output logic                JALDstM,
   output logic [1:0]          MaskOpM,
   output logic                LoadSignedM
);

   localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(0);
   localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(1);
   localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(2);
   localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(3);
   localparam logic [ALU_OP_W-1:0] ALU_XOR  = ALU_OP_W'(4);
   localparam logic [ALU_OP_W-1:0] ALU_NOR  = ALU_OP_W'(5);
   localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(6);
   localparam logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(7);
   localparam logic [ALU_OP_W-1:0] ALU_SLL  = ALU_OP_W'(8);
   localparam logic [ALU_OP_W-1:0] ALU_SRL  = ALU_OP_W'(9);
   localparam logic [ALU_OP_W-1:0] ALU_SRA  = ALU_OP_W'(10);

   localparam logic [1:0] SRC_REG   = 2'b00;
   localparam logic [1:0] SRC_IMM   = 2'b01;
   localparam logic [1:0] SRC_LUI   = 2'b10;
   localparam logic [1:0] SRC_SHAMT = 2'b11;

   localparam logic [1:0] MASK_WORD = 2'b00;
   localparam logic [1:0] MASK_BYTE = 2'b01;
   localparam logic [1:0] MASK_HALF = 2'b10;

   typedef struct packed {
      logic       valid;
      logic       regWrite;
      logic       memWrite;
      logic       memToReg;
      logic       jump;
      logic       jalVal;
      logic       jalDst;
      logic [1:0] maskOp;
      logic       loadSigned;
   } mCtl_t;

   typedef struct packed {
      logic                valid;
      logic                signOrZero;
      logic                regDst;
      logic [1:0]          aluSrc;
      logic [ALU_OP_W-1:0] aluCtrl;
      logic                branch;
      logic [2:0]          brCond;
      logic [4:0]          rs;
      logic [4:0]          rt;
      logic [4:0]          rd;
      mCtl_t               m;
   } eCtl_t;

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       legal;
   logic       readsRt;
   logic       accept;
   logic       luHit;
   logic       unusedShamt;
   eCtl_t      dec;
   eCtl_t      decWord;
   eCtl_t      eReg;
   mCtl_t      mChain [M_DELAY];
   logic       illegalNext;
   logic       illegalReg;

   assign opcode      = InstrD[31:26];
   assign funct       = InstrD[5:0];
   assign unusedShamt = ^InstrD[10:6];

   always_comb begin
      dec   = '0;
      legal = 1'b1;
      case (opcode)
         6'h00: begin
            dec.regDst     = 1'b1;
            dec.m.regWrite = 1'b1;
            case (funct)
               6'h00: begin dec.aluSrc = SRC_SHAMT; dec.aluCtrl = ALU_SLL; end
               6'h02: begin dec.aluSrc = SRC_SHAMT; dec.aluCtrl = ALU_SRL; end
               6'h03: begin dec.aluSrc = SRC_SHAMT; dec.aluCtrl = ALU_SRA; end
               6'h04: dec.aluCtrl = ALU_SLL;
               6'h06: dec.aluCtrl = ALU_SRL;
               6'h07: dec.aluCtrl = ALU_SRA;
               6'h08: begin dec.m.regWrite = 1'b0; dec.m.jump = 1'b1; end
               6'h09: begin dec.m.jump = 1'b1; dec.m.jalVal = 1'b1; end
               6'h20, 6'h21: dec.aluCtrl = ALU_ADD;
               6'h22, 6'h23: dec.aluCtrl = ALU_SUB;
               6'h24: dec.aluCtrl = ALU_AND;
               6'h25: dec.aluCtrl = ALU_OR;
               6'h26: dec.aluCtrl = ALU_XOR;
               6'h27: dec.aluCtrl = ALU_NOR;
               6'h2A: dec.aluCtrl = ALU_SLT;
               6'h2B: dec.aluCtrl = ALU_SLTU;
               default: legal = 1'b0;
            endcase
         end
         // REGIMM: rt[0] picks BGEZ over BLTZ
         6'h01: begin
            dec.branch     = 1'b1;
            dec.signOrZero = 1'b1;
            dec.aluCtrl    = ALU_SUB;
            dec.brCond     = InstrD[16] ? 3'd5 : 3'd4;
         end
         6'h02: dec.m.jump = 1'b1;
         6'h03: begin
            dec.m.jump     = 1'b1;
            dec.m.jalVal   = 1'b1;
            dec.m.jalDst   = 1'b1;
            dec.m.regWrite = 1'b1;
         end
         6'h04, 6'h05, 6'h06, 6'h07: begin
            dec.branch     = 1'b1;
            dec.signOrZero = 1'b1;
            dec.aluCtrl    = ALU_SUB;
            dec.brCond     = {1'b0, opcode[1:0]};
         end
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
            dec.aluSrc     = SRC_IMM;
            dec.m.regWrite = 1'b1;
            dec.signOrZero = !opcode[2];
            case (opcode[2:0])
               3'd0, 3'd1: dec.aluCtrl = ALU_ADD;
               3'd2:       dec.aluCtrl = ALU_SLT;
               3'd3:       dec.aluCtrl = ALU_SLTU;
               3'd4:       dec.aluCtrl = ALU_AND;
               3'd5:       dec.aluCtrl = ALU_OR;
               3'd6:       dec.aluCtrl = ALU_XOR;
               default: begin dec.aluSrc = SRC_LUI; dec.aluCtrl = ALU_ADD; end
            endcase
         end
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
            dec.aluSrc       = SRC_IMM;
            dec.signOrZero   = 1'b1;
            dec.aluCtrl      = ALU_ADD;
            dec.m.regWrite   = 1'b1;
            dec.m.memToReg   = 1'b1;
            dec.m.loadSigned = !opcode[2];
            case (opcode[1:0])
               2'd0:    dec.m.maskOp = MASK_BYTE;
               2'd1:    dec.m.maskOp = MASK_HALF;
               default: dec.m.maskOp = MASK_WORD;
            endcase
         end
         6'h28, 6'h29, 6'h2B: begin
            dec.aluSrc     = SRC_IMM;
            dec.signOrZero = 1'b1;
            dec.aluCtrl    = ALU_ADD;
            dec.m.memWrite = 1'b1;
            case (opcode[1:0])
               2'd0:    dec.m.maskOp = MASK_BYTE;
               2'd1:    dec.m.maskOp = MASK_HALF;
               default: dec.m.maskOp = MASK_WORD;
            endcase
         end
         default: legal = 1'b0;
      endcase
      dec.valid   = 1'b1;
      dec.m.valid = 1'b1;
      dec.rs      = InstrD[25:21];
      dec.rt      = InstrD[20:16];
      dec.rd      = InstrD[15:11];
   end

   always_comb begin
      decWord     = dec;
      illegalNext = 1'b0;
      if (!legal) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
         decWord     = '0;
         illegalNext = 1'b1;
`else
         decWord         = '0;
         decWord.valid   = 1'b1;
         decWord.m.valid = 1'b1;
`endif
      end
   end

   assign readsRt = (opcode == 6'h00) || (opcode == 6'h04) || (opcode == 6'h05) ||
                    (opcode == 6'h28) || (opcode == 6'h29) || (opcode == 6'h2B);

   assign luHit = eReg.valid && eReg.m.memToReg && (eReg.rt != 5'd0) && ValidD &&
                  ((eReg.rt == InstrD[25:21]) || ((eReg.rt == InstrD[20:16]) && readsRt));

   assign LoadUseStall = (LU_INTLK != 0) && luHit;
   assign ReadyD       = !StallE && !LoadUseStall;
   assign accept       = ValidD && ReadyD;

   // Flush wins over stall and accept; a non-accepting cycle inserts a bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eReg       <= '0;
         illegalReg <= 1'b0;
      end else if (FlushE) begin
         eReg       <= '0;
         illegalReg <= 1'b0;
      end else if (!StallE) begin
         eReg       <= accept ? decWord : '0;
         illegalReg <= accept && illegalNext;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < M_DELAY; i++) mChain[i] <= '0;
      end else if (!StallE) begin
         mChain[0] <= eReg.m;
         for (int i = 1; i < M_DELAY; i++) mChain[i] <= mChain[i-1];
      end
   end

   assign ValidE      = eReg.valid;
   assign SignOrZeroE = eReg.signOrZero;
   assign RegDstE     = eReg.regDst;
   assign ALUSrcE     = eReg.aluSrc;
   assign ALUCtrlE    = eReg.aluCtrl;
   assign BranchE     = eReg.branch;
   assign BrCondE     = eReg.brCond;
   assign RsE         = eReg.rs;
   assign RtE         = eReg.rt;
   assign RdE         = eReg.rd;

`ifdef DECODE_ILLEGAL_TRAP_EN
   assign IllegalE = illegalReg;
`else
   logic unusedIllegal;
   assign unusedIllegal = illegalReg;
`endif

   assign ValidM      = mChain[M_DELAY-1].valid;
   assign RegWriteM   = mChain[M_DELAY-1].regWrite;
   assign MemWriteM   = mChain[M_DELAY-1].memWrite;
   assign MemToRegM   = mChain[M_DELAY-1].memToReg;
   assign JumpM       = mChain[M_DELAY-1].jump;
   assign JALValM     = mChain[M_DELAY-1].jalVal;
   assign JALDstM     = mChain[M_DELAY-1].jalDst;
   assign MaskOpM     = mChain[M_DELAY-1].maskOp;
   assign LoadSignedM = mChain[M_DELAY-1].loadSigned;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb/tb_ctrl_decode_pipe.sv - directed self-checking bench for ctrl_decode_pipe, M_DELAY=1..4 side by side
module tb_ctrl_decode_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instrD;
   logic        validD;
   logic        stallE;
   logic        flushE;

   logic       readyD [4];
   logic       luStall [4];
   logic       validE [4];
   logic       signOrZeroE [4];
   logic       regDstE [4];
   logic [1:0] aluSrcE [4];
   logic [3:0] aluCtrlE [4];
   logic       branchE [4];
   logic [2:0] brCondE [4];
   logic [4:0] rsE [4];
   logic [4:0] rtE [4];
   logic [4:0] rdE [4];
   logic       validM [4];
   logic       regWriteM [4];
   logic       memWriteM [4];
   logic       memToRegM [4];
   logic       jumpM [4];
   logic       jalValM [4];
   logic       jalDstM [4];
   logic [1:0] maskOpM [4];
   logic       loadSignedM [4];
`ifdef DECODE_ILLEGAL_TRAP_EN
   logic       illegalE [4];
`endif

   int nCompared   = 0;
   int nMismatched = 0;
   int pulses;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : gDut
      ctrl_decode_pipe #(.ALU_OP_W(4), .M_DELAY(g + 1), .LU_INTLK(1)) dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .InstrD      (instrD),
         .ValidD      (validD),
         .ReadyD      (readyD[g]),
         .StallE      (stallE),
         .FlushE      (flushE),
         .LoadUseStall(luStall[g]),
         .ValidE      (validE[g]),
         .SignOrZeroE (signOrZeroE[g]),
         .RegDstE     (regDstE[g]),
         .ALUSrcE     (aluSrcE[g]),
         .ALUCtrlE    (aluCtrlE[g]),
         .BranchE     (branchE[g]),
         .BrCondE     (brCondE[g]),
         .RsE         (rsE[g]),
         .RtE         (rtE[g]),
         .RdE         (rdE[g]),
`ifdef DECODE_ILLEGAL_TRAP_EN
         .IllegalE    (illegalE[g]),
`endif
         .ValidM      (validM[g]),
         .RegWriteM   (regWriteM[g]),
         .MemWriteM   (memWriteM[g]),
         .MemToRegM   (memToRegM[g]),
         .JumpM       (jumpM[g]),
         .JALValM     (jalValM[g]),
         .JALDstM     (jalDstM[g]),
         .MaskOpM     (maskOpM[g]),
         .LoadSignedM (loadSignedM[g])
      );
   end

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // {ValidE, SignOrZeroE, RegDstE, ALUSrcE, ALUCtrlE, BranchE, BrCondE}
   logic [31:0] tblInstr [6] = '{32'h24220005, 32'h302200FF, 32'h000220C0,
                                 32'h04210002, 32'h3C021234, 32'h14220003};
   logic [12:0] tblExp [6]   = '{13'b1_1_0_01_0000_0_000, 13'b1_0_0_01_0010_0_000,
                                 13'b1_0_1_11_1000_0_000, 13'b1_1_0_00_0001_1_101,
                                 13'b1_0_0_10_0000_0_000, 13'b1_1_0_00_0001_1_001};

   initial begin
      rst_n  = 1'b0;
      instrD = 32'h0;
      validD = 1'b0;
      stallE = 1'b0;
      flushE = 1'b0;
      #1;
      checkVal("rst_validE", validE[0], 0);
      checkVal("rst_validM", validM[3], 0);
      checkVal("rst_regWriteM", regWriteM[0], 0);
      checkVal("rst_readyD", readyD[0], 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // ADDIU r2,r1,5 and M latency for every M_DELAY
      instrD = 32'h24220005;
      validD = 1'b1;
      step();
      validD = 1'b0;
      checkVal("addiu_validE", validE[0], 1);
      checkVal("addiu_aluSrcE", aluSrcE[0], 2'b01);
      checkVal("addiu_signOrZeroE", signOrZeroE[0], 1);
      checkVal("addiu_regDstE", regDstE[0], 0);
      checkVal("addiu_rsrt", {rsE[0], rtE[0]}, {5'd1, 5'd2});
      for (int d = 0; d < 4; d++) checkVal($sformatf("addiu_regWriteM_k0_d%0d", d + 1), regWriteM[d], 0);
      for (int k = 1; k <= 4; k++) begin
         step();
         for (int d = 0; d < 4; d++)
            checkVal($sformatf("addiu_regWriteM_k%0d_d%0d", k, d + 1), regWriteM[d], (k == d + 1) ? 1 : 0);
      end

      // LW r3 then ADDU r4,r3,r2: one bubble
      instrD = 32'h8C230000;
      validD = 1'b1;
      step();
      instrD = 32'h00622021;
      #1;
      checkVal("lu_stall", luStall[0], 1);
      checkVal("lu_readyD", readyD[0], 0);
      step();
      checkVal("lu_bubble_validE", validE[0], 0);
      checkVal("lu_memToRegM", memToRegM[0], 1);
      checkVal("lu_stall_released", luStall[0], 0);
      checkVal("lu_readyD_back", readyD[0], 1);
      step();
      validD = 1'b0;
      checkVal("lu_addu_validE", validE[0], 1);
      checkVal("lu_addu_regs", {rsE[0], rtE[0], rdE[0]}, {5'd3, 5'd2, 5'd4});
      checkVal("lu_addu_regDstE", regDstE[0], 1);

      // LW r0 then ADDU r4,r0,r2: no interlock
      instrD = 32'h8C200000;
      validD = 1'b1;
      step();
      instrD = 32'h00022021;
      #1;
      checkVal("lu_r0_stall", luStall[0], 0);
      checkVal("lu_r0_readyD", readyD[0], 1);
      step();
      validD = 1'b0;
      checkVal("lu_r0_validE", validE[0], 1);
      checkVal("lu_r0_rdE", rdE[0], 4);
      step();

      // SW r5,4(r1) held by a 3-cycle stall
      instrD = 32'hAC250004;
      validD = 1'b1;
      step();
      validD = 1'b0;
      stallE = 1'b1;
      #1;
      checkVal("stall_readyD", readyD[0], 0);
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         checkVal($sformatf("stall_validE_%0d", k), validE[0], 1);
         checkVal($sformatf("stall_rtE_%0d", k), rtE[0], 5);
         pulses += int'(memWriteM[0]);
      end
      stallE = 1'b0;
      step();
      pulses += int'(memWriteM[0]);
      checkVal("stall_memWriteM", memWriteM[0], 1);
      step();
      pulses += int'(memWriteM[0]);
      checkVal("stall_memWrite_pulses", pulses, 1);

      // BEQ in E with FlushE and StallE together
      instrD = 32'h24220005;
      validD = 1'b1;
      step();
      instrD = 32'h10220003;
      step();
      validD = 1'b0;
      checkVal("beq_branchE", branchE[0], 1);
      checkVal("beq_brCondE", brCondE[0], 0);
      checkVal("beq_regWriteM", regWriteM[0], 1);
      flushE = 1'b1;
      stallE = 1'b1;
      step();
      checkVal("flush_validE", validE[0], 0);
      checkVal("flush_branchE", branchE[0], 0);
      checkVal("flush_m_hold_regWrite", regWriteM[0], 1);
      checkVal("flush_m_hold_validM", validM[0], 1);
      stallE = 1'b0;
      instrD = 32'h24220005;
      validD = 1'b1;
      #1;
      checkVal("flush_drop_readyD", readyD[0], 1);
      step();
      checkVal("flush_drop_validE", validE[0], 0);
      flushE = 1'b0;
      validD = 1'b0;
      step();

      // decode table
      validD = 1'b1;
      for (int i = 0; i < 6; i++) begin
         instrD = tblInstr[i];
         step();
         checkVal($sformatf("decode_%0d", i),
                  {validE[0], signOrZeroE[0], regDstE[0], aluSrcE[0], aluCtrlE[0], branchE[0], brCondE[0]},
                  tblExp[i]);
      end
      validD = 1'b0;
      step();

      // undefined opcode 0x3F
      instrD = 32'hFC000000;
      validD = 1'b1;
      step();
      validD = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      checkVal("ill_illegalE", illegalE[0], 1);
      checkVal("ill_validE", validE[0], 0);
      step();
      checkVal("ill_cleared", illegalE[0], 0);
      checkVal("ill_validM", validM[0], 0);
`else
      checkVal("nop_validE", validE[0], 1);
      checkVal("nop_fields", {regDstE[0], aluSrcE[0], branchE[0]}, 0);
      step();
      checkVal("nop_validM", validM[0], 1);
      checkVal("nop_regWriteM", regWriteM[0], 0);
`endif

      // reset in mid-flight
      instrD = 32'h24220005;
      validD = 1'b1;
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      checkVal("midrst_validE", validE[0], 0);
      checkVal("midrst_regWriteM", regWriteM[0], 0);
      checkVal("midrst_validM_d4", validM[3], 0);
      validD = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
